// File: rtl/fp_sqrt_pkg.sv
// rtl/fp_sqrt_pkg.sv - FP32 field constants, tag type and operand classification for the sqrt scheduler
package fp_sqrt_pkg;

    localparam int          SIGN_BIT = 31;
    localparam int          EXP_MSB  = 30;
    localparam int          EXP_LSB  = 23;
    localparam int          MANT_W   = 23;
    localparam logic [7:0]  EXP_ALL1 = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    // Tag id field is sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
        logic                inv;
    } sqrt_tag_t;

    // sqrt is invalid for any NaN and for any negative value other than -0.
    function automatic logic is_invalid_operand(input logic [31:0] x);
        logic is_nan;
        logic is_neg;
        is_nan = (x[EXP_MSB:EXP_LSB] == EXP_ALL1) && (x[MANT_W-1:0] != '0);
        is_neg = x[SIGN_BIT] && (x[SIGN_BIT-1:0] != '0);
        return is_nan || is_neg;
    endfunction

endpackage

// File: rtl/fp_sqrt_scheduler_if.sv
// rtl/fp_sqrt_scheduler_if.sv - requester-side request/response bundle of the sqrt scheduler
// master: requester side (drives req_valid/req_operand, receives ready and responses)
// slave : scheduler side
interface fp_sqrt_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_operand;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [31:0]           resp_result;
    logic                  resp_invalid;

    modport master (
        output req_valid, req_operand,
        input  req_ready, resp_valid, resp_result, resp_invalid
    );

    modport slave (
        input  req_valid, req_operand,
        output req_ready, resp_valid, resp_result, resp_invalid
    );
endinterface

// File: rtl/fp_sqrt_scheduler_rr_arbiter.sv
// rtl/fp_sqrt_scheduler_rr_arbiter.sv - round-robin arbiter with combinational one-hot grant
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   grant      : one-hot grant of first request at or after the pointer (wrapping)
//   grant_any  : some request was granted
//   grant_id   : binary index of the granted request
// The pointer moves past the granted requester on every grant; a grant is an accept.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_any,
    output logic [ID_W-1:0]    grant_id
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] sel;

    // First pass searches [rr_ptr, NUM_REQ), second pass wraps to [0, rr_ptr).
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        sel       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req[i] && (PTR_W'(i) >= rr_ptr)) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                sel       = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req[i]) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                sel       = PTR_W'(i);
            end
        end
    end

    assign grant_id = ID_W'(sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fp_sqrt_scheduler.sv
// rtl/fp_sqrt_scheduler.sv - shares one fixed-latency FP32 sqrt datapath between NUM_REQ requesters
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 0 blocks new grants; in-flight ops still complete
//   flush       : kills all in-flight tags, no grant this cycle
//   bus         : requester bundle (req_valid/req_operand/req_ready, resp_valid/resp_result/resp_invalid)
//   sq_issue    : registered operand-valid to the datapath
//   sq_operand  : registered operand to the datapath
//   sq_result   : datapath result, valid LATENCY cycles after sq_issue
//   issue_count : wrapping count of grants since reset
module fp_sqrt_scheduler
    import fp_sqrt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      flush,
    fp_sqrt_scheduler_if.slave        bus,
    output logic                      sq_issue,
    output logic [31:0]               sq_operand,
    input  logic [31:0]               sq_result,
    output logic [15:0]               issue_count
);

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [31:0]        grant_operand;
    logic               grant_inv;
    logic [NUM_REQ-1:0] resp_onehot;

    // Entry 0 travels alongside sq_issue; entry LATENCY lines up with sq_result.
    sqrt_tag_t tag_q [LATENCY+1];

    assign cand = bus.req_valid & {NUM_REQ{enable & ~flush}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (cand),
        .grant     (grant),
        .grant_any (grant_any),
        .grant_id  (grant_id)
    );

    assign bus.req_ready = grant;

    always_comb begin
        grant_operand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_operand = bus.req_operand[32*i +: 32];
            end
        end
    end

    assign grant_inv = is_invalid_operand(grant_operand);

    always_comb begin
        resp_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_onehot[i] = (tag_q[LATENCY].id == TAG_ID_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            sq_issue         <= 1'b0;
            sq_operand       <= '0;
            issue_count      <= '0;
            bus.resp_valid   <= '0;
            bus.resp_result  <= '0;
            bus.resp_invalid <= 1'b0;
        end else begin
            // grant_any is already low during flush, so entry 0 loads invalid.
            tag_q[0] <= '{v: grant_any, id: TAG_ID_W'(grant_id), inv: grant_inv};
            for (int k = 1; k <= LATENCY; k++) begin
                tag_q[k] <= '{v: tag_q[k-1].v & ~flush, id: tag_q[k-1].id, inv: tag_q[k-1].inv};
            end

            sq_issue <= grant_any;
            if (grant_any) begin
                sq_operand  <= grant_operand;
                issue_count <= issue_count + 16'd1;
            end

            // A flush also kills the tag whose result is on sq_result right now;
            // a pulse already registered on resp_valid is unaffected.
            if (tag_q[LATENCY].v && !flush) begin
                bus.resp_valid   <= resp_onehot;
                bus.resp_result  <= sq_result;
                bus.resp_invalid <= tag_q[LATENCY].inv;
            end else begin
                bus.resp_valid   <= '0;
            end
        end
    end

endmodule

// File: doc/fp_sqrt_scheduler.md
Name: fp_sqrt_scheduler

Overview:
- Shares one fixed-latency FP32 square-root datapath between NUM_REQ requesters.
- Per cycle, round-robin selects at most one valid request and issues its operand to the datapath.
- Tags each issued op with requester ID and an invalid-operation flag, then routes the datapath result back to the owning requester.
- Sits between the FP issue ports and the single sqrt datapath instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-ID width; must be >= clog2(NUM_REQ).
- LATENCY, 2, cycles from datapath sampling sq_issue to sq_result valid (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when 0, no new grants; in-flight ops still drain.
- flush  in  1  synchronous; kills all in-flight tags, no grants this cycle.
- req_valid  in  NUM_REQ  per-requester request.
- req_operand  in  32*NUM_REQ  FP32 operands; requester i at bits [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- sq_issue  out  1  operand valid to datapath, registered.
- sq_operand  out  32  operand to datapath, registered.
- sq_result  in  32  datapath result, valid exactly LATENCY cycles after sq_issue.
- resp_valid  out  NUM_REQ  one-hot, one-cycle pulse, registered.
- resp_result  out  32  result for the pulsing requester.
- resp_invalid  out  1  IEEE invalid flag for the pulsing requester.
- issue_count  out  16  total grants since reset; wraps at 0xFFFF->0.

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr=0; tag pipeline cleared.
  - sq_issue=0, sq_operand=0; resp_valid=0, resp_result=0, resp_invalid=0; issue_count=0.
- Arbitration (combinational):
  - Candidates are req_valid & {NUM_REQ{enable & ~flush}}.
  - Grant the first candidate at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready is that one-hot grant. req_ready may depend on req_valid; requesters must hold valid and operand until ready.
- Pointer: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Issue stage (registered):
  - sq_issue <= grant_any.
  - sq_operand <= granted operand; holds its old value when there is no grant.
  - issue_count increments on each grant.
- Invalid detection at grant time, on the granted operand:
  - inv = NaN (exp==FF, mant!=0) OR (sign==1 AND NOT (exp==0 AND mant==0)).
  - -0 and +inf are not invalid.
- Tag pipeline:
  - Shift register of depth LATENCY+1; each entry is {v, id[ID_W-1:0], inv}.
  - Entry 0 loads {grant_any, grant_id, inv} in step with sq_issue.
  - Entries advance every cycle with no stalls.
  - The last entry aligns with the cycle in which sq_result is valid.
- Response stage (registered), when the last entry has v=1:
  - resp_valid[id] <= 1; resp_result <= sq_result; resp_invalid <= inv.
  - Otherwise resp_valid <= 0; resp_result and resp_invalid hold.
- Latency: handshake at edge t -> sq_issue high in cycle t+1 -> resp_valid pulse in cycle t+LATENCY+2.
- Throughput: 1 op/cycle. There is no response backpressure; requesters must accept the pulse.
- Flush:
  - Clears all tag v bits and forces sq_issue <= 0 at that edge.
  - Responses already registered this cycle still appear.
  - Datapath results returning for killed tags are discarded.
  - A flush concurrent with a response pulse does not cancel that pulse.
- enable=0 mid-stream: in-flight ops complete normally; only new grants stop.
- Simultaneous grant and response to the same requester are independent and both occur.
- NUM_REQ=1: the arbiter degenerates to pass-through; rr_ptr stays 0.

Decomposition:
- Package fp_sqrt_pkg holds:
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MANT_W=23, EXP_ALL1=8'hFF.
  - The canonical quiet NaN constant QNAN=32'h7FC00000.
  - The tag struct/typedef {v, id, inv}.
  - The is_invalid_operand function.
- Sub-module rr_arbiter (NUM_REQ param: req in, grant one-hot out, ptr update on accept). Reusable elsewhere.

Test Plan:
- Single request, LATENCY=2: req0 operand 0x40800000 (4.0) at edge 0 -> sq_issue high in cycle 1 with 0x40800000. Model returns 0x40000000 -> resp_valid=0001 in cycle 4, resp_result=0x40000000, resp_invalid=0, issue_count=1.
- Fairness: all four requesters valid continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3. Each resp pulse carries the matching id; issue_count=8.
- Invalid flags:
  - Operand 0xC0800000 (-4.0) -> resp_invalid=1.
  - 0x80000000 (-0) -> resp_invalid=0.
  - 0x7F800001 (sNaN) -> resp_invalid=1.
  - 0x7F800000 (+inf) -> resp_invalid=0.
- Flush: issue to req1 and req2 on consecutive cycles, assert flush one cycle later -> no resp_valid for either op. The next grant goes to req3 when all are valid, since rr_ptr is not reset by flush.
- enable low: drop enable the cycle after two issues -> req_ready stays 0 while enable is low, and both in-flight responses still pulse at t+LATENCY+2.
- Async reset mid-stream: assert rst_n=0 between edges with 3 ops in flight -> all outputs are 0 immediately, and no stale resp_valid appears after release. Also wrap check: preload 0xFFFF grants, one more grant -> issue_count=0x0000.
